// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 from a 100 MHz clock) and the
// per-axis raster phase type.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CLK_DIV_DEF  = 4;
  localparam int CW_DEF       = 11;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } axis_phase_e;

  function automatic logic sync_level(input axis_phase_e ph, input logic pol);
    return (ph == PH_SYNC) ? pol : !pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap plus ACTIVE/FP/SYNC/BP phase FSM.
// The phase port is the phase the counter will hold after this edge, so the
// parent can register sync/active in lock-step with the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          wrap,
  output axis_phase_e   phase
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] FP_AT   = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_AT = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] BP_AT   = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] count_q, count_d;
  axis_phase_e   phase_q, phase_d;

  // Next count and the phase boundary crossing it implies.
  always_comb begin
    count_d = count_q;
    if (step) begin
      if (count_q == LAST) count_d = '0;
      else                 count_d = count_q + 1'b1;
    end else begin
      count_d = count_q;
    end

    phase_d = phase_q;
    case (phase_q)
      PH_ACTIVE: if (count_d == FP_AT)   phase_d = PH_FP;     else phase_d = PH_ACTIVE;
      PH_FP:     if (count_d == SYNC_AT) phase_d = PH_SYNC;   else phase_d = PH_FP;
      PH_SYNC:   if (count_d == BP_AT)   phase_d = PH_BP;     else phase_d = PH_SYNC;
      PH_BP:     if (count_d == '0)      phase_d = PH_ACTIVE; else phase_d = PH_BP;
      default:   phase_d = PH_ACTIVE;
    endcase
  end

  // Count and phase state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count = count_q;
  assign wrap  = step && (count_q == LAST);
  assign phase = phase_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel clock-enable divider, horizontal and vertical
// axis counters, registered sync/active outputs and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter int   CLK_DIV  = CLK_DIV_DEF,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic          h_wrap, v_step, v_wrap_unused;
  axis_phase_e   h_phase, v_phase;

  // Tick is masked while rst is held so the CLK_DIV=1 build stays quiet in reset.
  assign pix_ce = (div_q == DIV_LAST) && !rst;
  assign v_step = pix_ce && h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .CW (CW)
  ) u_h (
    .clk (clk), .rst (rst), .step (pix_ce),
    .count (x), .wrap (h_wrap), .phase (h_phase)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .CW (CW)
  ) u_v (
    .clk (clk), .rst (rst), .step (v_step),
    .count (y), .wrap (v_wrap_unused), .phase (v_phase)
  );

  // Divider wrap and output levels for the position the counters move to.
  always_comb begin
    if (div_q == DIV_LAST) div_d = '0;
    else                   div_d = div_q + 1'b1;
    hsync_d  = sync_level(h_phase, SYNC_POL);
    vsync_d  = sync_level(v_phase, SYNC_POL);
    active_d = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  end

  // Divider and registered raster outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      hsync_q  <= !SYNC_POL;
      vsync_q  <= !SYNC_POL;
      active_q <= 1'b1;
    end else begin
      div_q    <= div_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = pix_ce && (x == '0);
  assign frame_start = line_start && (y == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (default, short-frame, tiny) compared
// cycle by cycle against a position-from-elapsed-time reference model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

  logic ce_a, hs_a, vs_a, act_a, ls_a, fs_a;
  logic ce_b, hs_b, vs_b, act_b, ls_b, fs_b;
  logic ce_c, hs_c, vs_c, act_c, ls_c, fs_c;
  logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic [27:0] obs_a, obs_b, obs_c;

  assign obs_a = {ce_a, hs_a, vs_a, act_a, ls_a, fs_a, x_a, y_a};
  assign obs_b = {ce_b, hs_b, vs_b, act_b, ls_b, fs_b, x_b, y_b};
  assign obs_c = {ce_c, hs_c, vs_c, act_c, ls_c, fs_c, x_c, y_c};

  vga_timing_gen u_a (
    .clk (clk), .rst (rst_a), .pix_ce (ce_a), .hsync (hs_a), .vsync (vs_a),
    .active (act_a), .x (x_a), .y (y_a), .line_start (ls_a), .frame_start (fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .CLK_DIV (1), .SYNC_POL (1'b1), .CW (11)
  ) u_b (
    .clk (clk), .rst (rst_b), .pix_ce (ce_b), .hsync (hs_b), .vsync (vs_b),
    .active (act_b), .x (x_b), .y (y_b), .line_start (ls_b), .frame_start (fs_b)
  );

  vga_timing_gen #(
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1), .CLK_DIV (2)
  ) u_c (
    .clk (clk), .rst (rst_c), .pix_ce (ce_c), .hsync (hs_c), .vsync (vs_c),
    .active (act_c), .x (x_c), .y (y_c), .line_start (ls_c), .frame_start (fs_c)
  );

  int checks = 0;
  int errors = 0;
  int na, nb, nc;

  // Expected outputs n clk cycles after reset release, derived from elapsed pixels.
  function automatic logic [27:0] model(input int n, input int dv,
      input int ha, input int hf, input int hsw, input int hb,
      input int va, input int vf, input int vsw, input int vb, input bit pol);
    int ht, vt, p, xx, yy;
    logic ce, hsy, vsy, act;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    p   = n / dv;
    xx  = p % ht;
    yy  = (p / ht) % vt;
    ce  = ((n % dv) == dv - 1);
    hsy = (xx >= ha + hf && xx < ha + hf + hsw) ? pol : !pol;
    vsy = (yy >= va + vf && yy < va + vf + vsw) ? pol : !pol;
    act = (xx < ha) && (yy < va);
    return {ce, hsy, vsy, act, ce && xx == 0, ce && xx == 0 && yy == 0, 11'(xx), 11'(yy)};
  endfunction

  task automatic test_reset;
    logic [27:0] exp;
    int waited;
    exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 22'd0};
    @(negedge clk); rst_a = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs_a !== exp) begin errors++; $display("FAIL reset_a got=%h exp=%h", obs_a, exp); end
    rst_a = 1'b0; #1; na = 0;
    waited = 0;
    while (ce_a !== 1'b1 && waited < 10) begin
      @(negedge clk); #1; na++; waited++;
    end
    checks++;
    if (na !== 3) begin errors++; $display("FAIL first_pix_ce cycle got=%0d exp=3", na); end
    checks++;
    if ({fs_a, ls_a, act_a, hs_a, vs_a, x_a, y_a} !== {5'b11111, 22'd0}) begin
      errors++;
      $display("FAIL first_tick got=%b exp=%b", {fs_a, ls_a, act_a, hs_a, vs_a, x_a, y_a}, {5'b11111, 22'd0});
    end
  endtask

  task automatic test_horizontal;
    logic [27:0] exp;
    logic prev_hs;
    int fall_n, rise_n, ls1, ls2;
    logic [10:0] fall_x, rise_x;
    fall_n = -1; rise_n = -1; ls1 = -1; ls2 = -1; fall_x = '0; rise_x = '0;
    prev_hs = hs_a;
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk); #1; na++;
      exp = model(na, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL horiz n=%0d got=%h exp=%h", na, obs_a, exp); end
      if (prev_hs && !hs_a && fall_n < 0) begin fall_n = na; fall_x = x_a; end
      if (!prev_hs && hs_a && fall_n >= 0 && rise_n < 0) begin rise_n = na; rise_x = x_a; end
      if (ls_a) begin
        if (ls1 < 0) ls1 = na;
        else if (ls2 < 0) ls2 = na;
      end
      prev_hs = hs_a;
    end
    checks++;
    if (fall_x !== 11'd656) begin errors++; $display("FAIL hsync_fall_x got=%0d exp=656", fall_x); end
    checks++;
    if (rise_x !== 11'd752) begin errors++; $display("FAIL hsync_rise_x got=%0d exp=752", rise_x); end
    checks++;
    if (rise_n - fall_n !== 384) begin errors++; $display("FAIL hsync_width got=%0d exp=384", rise_n - fall_n); end
    checks++;
    if (ls2 - ls1 !== 3200) begin errors++; $display("FAIL line_period got=%0d exp=3200", ls2 - ls1); end
  endtask

  task automatic test_reset_mid;
    logic [27:0] exp, rexp;
    int steps;
    rexp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 22'd0};
    steps = 0;
    while (!(((na / 4) % 800) == 700 && (na % 4) == 1) && steps < 4000) begin
      @(negedge clk); #1; na++; steps++;
      exp = model(na, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL pre_reset n=%0d got=%h exp=%h", na, obs_a, exp); end
    end
    checks++;
    if (x_a !== 11'd700 || ce_a !== 1'b0) begin
      errors++; $display("FAIL mid_reset_point got x=%0d ce=%b exp x=700 ce=0", x_a, ce_a);
    end
    rst_a = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (obs_a !== rexp) begin errors++; $display("FAIL mid_reset got=%h exp=%h", obs_a, rexp); end
    rst_a = 1'b0; #1; na = 0;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) begin @(negedge clk); #1; na++; end
      exp = model(na, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL restart n=%0d got=%h exp=%h", na, obs_a, exp); end
    end
  endtask

  task automatic test_vertical;
    logic [27:0] exp, rexp;
    logic prev_vs;
    int fs1, fs2, fall_n, rise_n;
    logic [21:0] fall_xy;
    rexp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 22'd0};
    fs1 = -1; fs2 = -1; fall_n = -1; rise_n = -1; fall_xy = '1;
    @(negedge clk); rst_c = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs_c !== rexp) begin errors++; $display("FAIL reset_c got=%h exp=%h", obs_c, rexp); end
    rst_c = 1'b0; #1; nc = 0;
    prev_vs = vs_c;
    for (int i = 0; i < 2 * 12800 + 100; i++) begin
      if (i > 0) begin @(negedge clk); #1; nc++; end
      exp = model(nc, 2, 640, 16, 96, 48, 4, 1, 2, 1, 1'b0);
      checks++;
      if (obs_c !== exp) begin errors++; $display("FAIL vert n=%0d got=%h exp=%h", nc, obs_c, exp); end
      if (prev_vs && !vs_c && fall_n < 0) begin fall_n = nc; fall_xy = {x_c, y_c}; end
      if (!prev_vs && vs_c && fall_n >= 0 && rise_n < 0) rise_n = nc;
      if (fs_c) begin
        if (fs1 < 0) fs1 = nc;
        else if (fs2 < 0) fs2 = nc;
      end
      prev_vs = vs_c;
    end
    checks++;
    if (fall_xy !== {11'd0, 11'd5}) begin errors++; $display("FAIL vsync_fall_xy got=%h exp=%h", fall_xy, {11'd0, 11'd5}); end
    checks++;
    if (rise_n - fall_n !== 3200) begin errors++; $display("FAIL vsync_width got=%0d exp=3200", rise_n - fall_n); end
    checks++;
    if (fs2 - fs1 !== 12800) begin errors++; $display("FAIL frame_period_c got=%0d exp=12800", fs2 - fs1); end
  endtask

  task automatic test_small;
    logic [27:0] exp, rexp;
    int fs1, fs2;
    rexp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 22'd0};
    fs1 = -1; fs2 = -1;
    @(negedge clk); rst_b = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs_b !== rexp) begin errors++; $display("FAIL reset_b got=%h exp=%h", obs_b, rexp); end
    rst_b = 1'b0; #1; nb = 0;
    for (int i = 0; i < 5 * 48; i++) begin
      if (i > 0) begin @(negedge clk); #1; nb++; end
      exp = model(nb, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1);
      checks++;
      if (obs_b !== exp) begin errors++; $display("FAIL small n=%0d got=%h exp=%h", nb, obs_b, exp); end
      if (fs_b) begin
        if (fs1 < 0) fs1 = nb;
        else if (fs2 < 0) fs2 = nb;
      end
    end
    checks++;
    if (fs2 - fs1 !== 48) begin errors++; $display("FAIL frame_period_b got=%0d exp=48", fs2 - fs1); end
  endtask

  task automatic test_back_to_back;
    logic [27:0] exp, rexp;
    int run, hold;
    rexp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 22'd0};
    for (int k = 0; k < 6; k++) begin
      run  = $urandom_range(1, 60);
      hold = $urandom_range(1, 3);
      for (int i = 0; i < run; i++) begin
        @(negedge clk); #1; nb++;
        exp = model(nb, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1);
        checks++;
        if (obs_b !== exp) begin errors++; $display("FAIL b2b_run n=%0d got=%h exp=%h", nb, obs_b, exp); end
      end
      rst_b = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); #1;
        checks++;
        if (obs_b !== rexp) begin errors++; $display("FAIL b2b_reset got=%h exp=%h", obs_b, rexp); end
      end
      rst_b = 1'b0; #1; nb = 0;
      exp = model(nb, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1);
      checks++;
      if (obs_b !== exp) begin errors++; $display("FAIL b2b_release got=%h exp=%h", obs_b, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_reset_mid();
    test_small();
    test_back_to_back();
    test_vertical();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
